// File: rtl/mem_pkg.sv
// Shared constants and types for the round-robin memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default address / data widths
//   arb_state_t             : arbiter FSM state encoding
package mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle between NUM_CH clients, the arbiter and one downstream memory port.
//   c_req/c_w_en/c_addr/c_wdata : per-channel requests from clients
//   c_ack/c_err/c_rdata         : completion back to clients (ack is per channel)
//   m_req/m_w_en/m_addr/m_wdata : request towards memory
//   m_ack/m_rdata               : memory completion
// modport master: the arbiter; modport slave: the clients + memory environment.
interface mem_rr_arbiter_if
  import mem_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [NUM_CH-1:0]             c_req;
  logic [NUM_CH-1:0]             c_w_en;
  logic [NUM_CH-1:0][ADDR_W-1:0] c_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] c_wdata;
  logic [NUM_CH-1:0]             c_ack;
  logic                          c_err;
  logic [DATA_W-1:0]             c_rdata;

  logic                          m_req;
  logic                          m_w_en;
  logic [ADDR_W-1:0]             m_addr;
  logic [DATA_W-1:0]             m_wdata;
  logic                          m_ack;
  logic [DATA_W-1:0]             m_rdata;

  modport master (
    input  c_req, c_w_en, c_addr, c_wdata, m_ack, m_rdata,
    output c_ack, c_err, c_rdata, m_req, m_w_en, m_addr, m_wdata
  );

  modport slave (
    output c_req, c_w_en, c_addr, c_wdata, m_ack, m_rdata,
    input  c_ack, c_err, c_rdata, m_req, m_w_en, m_addr, m_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req        : request vector, one bit per channel
//   last_grant : channel granted most recently
//   grant      : chosen channel; first requester found searching upward from
//                last_grant+1 with wrap-around
//   valid      : at least one request present
module rr_pick #(
  parameter int  NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  // Scan from the lowest priority (last_grant itself) towards the highest
  // (last_grant+1) so the final hit wins without an early exit.
  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (req[cand[IDX_W-1:0]]) begin
        grant = IDX_W'(cand);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter: shares one downstream memory port among NUM_CH clients,
// one transaction at a time, with a timeout on the memory acknowledge.
//   clk     : clock, everything on posedge
//   reset_n : asynchronous active-low reset
//   bus     : mem_rr_arbiter_if.master (client request/ack side + memory side)
//
// state   | meaning
// IDLE    | arbitrate; latch winner's grant index, addr, w_en, wdata
// ISSUE   | m_req high from latched fields; wait for m_ack or timeout
// ACK     | one-cycle c_ack to the winner with c_err / c_rdata
// RELEASE | quiet cycle so the client can drop c_req; no arbitration
module mem_rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_rr_arbiter_if.master bus
);

  localparam int          IDX_W    = $clog2(NUM_CH);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  arb_state_t        state_q, state_d;

  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              w_en_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [15:0]       tmo_cnt_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              tmo_hit;
  logic              m_req_c;
  logic [NUM_CH-1:0] ack_c;
  logic              err_c;

  rr_pick #(
    .NUM_CH(NUM_CH)
  ) u_pick (
    .req       (bus.c_req),
    .last_grant(last_grant_q),
    .grant     (pick_idx),
    .valid     (pick_valid)
  );

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    m_req_c = 1'b0;
    ack_c   = '0;
    err_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ISSUE;
      end
      ISSUE: begin
        m_req_c = 1'b1;
        if (bus.m_ack || tmo_hit) state_d = ACK;
      end
      ACK: begin
        ack_c[grant_q] = 1'b1;
        err_c          = err_q;
        state_d        = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction fields are latched once in IDLE so later c_req/c_addr
  // activity from any client cannot disturb the request already in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      addr_q       <= '0;
      w_en_q       <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q   <= pick_idx;
            addr_q    <= bus.c_addr[pick_idx];
            w_en_q    <= bus.c_w_en[pick_idx];
            wdata_q   <= bus.c_wdata[pick_idx];
            tmo_cnt_q <= '0;
          end
        end
        ISSUE: begin
          // An ack landing on the last allowed cycle still counts as success.
          if (bus.m_ack) begin
            rdata_q <= w_en_q ? '0 : bus.m_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        ACK: begin
          last_grant_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.m_req   = m_req_c;
  assign bus.m_w_en  = w_en_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.c_ack   = ack_c;
  assign bus.c_err   = err_c;
  assign bus.c_rdata = rdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: a table of single-channel
// transactions plus hand-written arbitration, reset and spurious-ack sequences.
module tb_mem_rr_arbiter;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 256;
  localparam int TIMEOUT_CYC = 8;
  localparam int NEVER       = 1000;
  localparam int NVEC        = 7;

  typedef struct {
    int                ch;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                delay;
    logic [DATA_W-1:0] rdata;
    bit                drop_early;
    bit                spur;
    bit                exp_err;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_issue;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  mem_rr_arbiter_if #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) bus ();

  mem_rr_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no c_ack within cycle budget", name);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous protocol checks, sampled mid-cycle.
  logic              prev_ok    = 1'b0;
  logic              prev_mreq  = 1'b0;
  logic              prev_we    = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ok = 1'b0;
    end else begin
      check("mon_ack_onehot", $onehot0(bus.c_ack), 1'b1);
      if (bus.c_ack == '0) check("mon_err_without_ack", bus.c_err, 1'b0);
      else                 check("mon_ack_follows_issue", {prev_ok, prev_mreq}, 2'b11);
      if (prev_ok && prev_mreq && bus.m_req) begin
        check("mon_maddr_stable", bus.m_addr, prev_addr);
        check("mon_mwdata_stable", bus.m_wdata, prev_wdata);
        check("mon_mwen_stable", bus.m_w_en, prev_we);
      end
      prev_ok = 1'b1;
    end
    prev_mreq  = bus.m_req;
    prev_we    = bus.m_w_en;
    prev_addr  = bus.m_addr;
    prev_wdata = bus.m_wdata;
  end

  // One transaction on a single channel; memory acks on the delay-th ISSUE cycle.
  task automatic run_txn(input vec_t v, input int idx);
    int issue_n;
    bit got;
    issue_n = 0;
    got     = 1'b0;
    bus.c_w_en[v.ch]  = v.we;
    bus.c_addr[v.ch]  = v.addr;
    bus.c_wdata[v.ch] = v.wdata;
    bus.m_rdata       = v.rdata;
    bus.c_req[v.ch]   = 1'b1;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      tick();
      bus.m_ack = 1'b0;
      if (cyc == 0) check($sformatf("v%0d_req_to_mreq", idx), bus.m_req, 1'b1);
      if (bus.c_ack != '0) begin
        got = 1'b1;
        check($sformatf("v%0d_c_ack", idx), bus.c_ack, 1 << v.ch);
        check($sformatf("v%0d_c_err", idx), bus.c_err, v.exp_err);
        check($sformatf("v%0d_c_rdata", idx), bus.c_rdata, v.exp_rdata);
        check($sformatf("v%0d_issue_cycles", idx), issue_n, v.exp_issue);
        bus.c_req[v.ch] = 1'b0;
        if (v.spur) bus.m_ack = 1'b1;
      end else if (bus.m_req) begin
        if (issue_n == 0) begin
          check($sformatf("v%0d_m_addr", idx), bus.m_addr, v.addr);
          check($sformatf("v%0d_m_w_en", idx), bus.m_w_en, v.we);
          check($sformatf("v%0d_m_wdata", idx), bus.m_wdata, v.wdata);
          if (v.drop_early) bus.c_req[v.ch] = 1'b0;
        end
        if (issue_n == v.delay) bus.m_ack = 1'b1;
        issue_n++;
      end
    end
    if (!got) expire($sformatf("v%0d_wait_ack", idx));
    tick();
    check($sformatf("v%0d_release_no_ack", idx), bus.c_ack, 0);
    check($sformatf("v%0d_release_no_mreq", idx), bus.m_req, 1'b0);
    tick();
    bus.m_ack = 1'b0;
    check($sformatf("v%0d_idle_no_ack", idx), bus.c_ack, 0);
  endtask

  // Memory acks every request immediately; waits for the next c_ack.
  task automatic await_grant(input int exp_ch, input bit drop, input string tag,
                             output int ncyc);
    bit got;
    got  = 1'b0;
    ncyc = 0;
    bus.m_rdata = {32{8'h3C}};
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      tick();
      bus.m_ack = 1'b0;
      if (bus.c_ack != '0) begin
        got  = 1'b1;
        ncyc = cyc + 1;
        check(tag, bus.c_ack, 1 << exp_ch);
        check({tag, "_err"}, bus.c_err, 1'b0);
        if (drop) bus.c_req[exp_ch] = 1'b0;
      end else if (bus.m_req) begin
        bus.m_ack = 1'b1;
      end
    end
    if (!got) expire(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    vecs[0] = '{ch:2, we:1'b0, addr:16'h0042, wdata:256'h0, delay:2, rdata:{32{8'hA5}},
                drop_early:1'b0, spur:1'b0, exp_err:1'b0, exp_rdata:{32{8'hA5}}, exp_issue:3};
    vecs[1] = '{ch:1, we:1'b1, addr:16'h1234, wdata:256'hDEAD, delay:0, rdata:{32{8'hFF}},
                drop_early:1'b0, spur:1'b1, exp_err:1'b0, exp_rdata:256'h0, exp_issue:1};
    vecs[2] = '{ch:0, we:1'b0, addr:16'hFFFF, wdata:256'h0, delay:0, rdata:256'h1,
                drop_early:1'b0, spur:1'b0, exp_err:1'b0, exp_rdata:256'h1, exp_issue:1};
    vecs[3] = '{ch:3, we:1'b0, addr:16'h8000, wdata:256'h0, delay:7, rdata:{32{8'h5A}},
                drop_early:1'b1, spur:1'b0, exp_err:1'b0, exp_rdata:{32{8'h5A}}, exp_issue:8};
    vecs[4] = '{ch:1, we:1'b0, addr:16'h0100, wdata:256'h0, delay:NEVER, rdata:{32{8'h77}},
                drop_early:1'b0, spur:1'b0, exp_err:1'b1, exp_rdata:256'h0, exp_issue:8};
    vecs[5] = '{ch:3, we:1'b1, addr:16'h3333, wdata:256'hBEEF, delay:NEVER, rdata:{32{8'h11}},
                drop_early:1'b0, spur:1'b0, exp_err:1'b1, exp_rdata:256'h0, exp_issue:8};
    vecs[6] = '{ch:0, we:1'b1, addr:16'h0001, wdata:{32{8'hC3}}, delay:5, rdata:{32{8'h99}},
                drop_early:1'b0, spur:1'b0, exp_err:1'b0, exp_rdata:256'h0, exp_issue:6};

    bus.c_req   = '0;
    bus.c_w_en  = '0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;

    // Reset values
    #1;
    check("rst_m_req", bus.m_req, 1'b0);
    check("rst_m_w_en", bus.m_w_en, 1'b0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_c_ack", bus.c_ack, 0);
    check("rst_c_err", bus.c_err, 1'b0);
    check("rst_c_rdata", bus.c_rdata, 0);
    tick();
    tick();
    check("rst_hold_m_req", bus.m_req, 1'b0);
    reset_n = 1'b1;
    tick();
    check("idle_no_req_m_req", bus.m_req, 1'b0);

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], i);

    // last_grant=0: ch1 and ch3 request, ch1 first; ch1 drops early,
    // ch2 joins mid-transaction and must win next.
    bus.c_w_en    = '0;
    bus.c_addr[1] = 16'h1111;
    bus.c_addr[2] = 16'h2222;
    bus.c_addr[3] = 16'h3333;
    bus.c_req[1]  = 1'b1;
    bus.c_req[3]  = 1'b1;
    tick();
    check("seq_m_req", bus.m_req, 1'b1);
    check("seq_m_addr_ch1", bus.m_addr, 16'h1111);
    bus.c_req[1] = 1'b0;
    bus.c_req[2] = 1'b1;
    await_grant(1, 1'b0, "seq_grant_ch1", ncyc);
    await_grant(2, 1'b1, "seq_grant_ch2", ncyc);
    await_grant(3, 1'b1, "seq_grant_ch3", ncyc);
    tick();
    tick();

    // m_ack with nothing in flight
    bus.m_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_spur_no_ack", bus.c_ack, 0);
      check("idle_spur_no_mreq", bus.m_req, 1'b0);
    end
    bus.m_ack = 1'b0;

    // All channels requesting continuously after reset
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    bus.c_w_en = '0;
    bus.c_req  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      await_grant(k % NUM_CH, 1'b0, $sformatf("rr_grant_%0d", k), ncyc);
      check($sformatf("rr_spacing_%0d", k), ncyc, (k == 0) ? 2 : 4);
    end
    bus.c_req = '0;
    tick();
    tick();

    // Reset in the middle of ISSUE (last_grant is 0 here, so ch3 would win
    // without the reset restoring channel 0 priority).
    bus.c_addr[1]  = 16'h0BAD;
    bus.c_w_en[1]  = 1'b1;
    bus.c_wdata[1] = {32{8'h6B}};
    bus.c_req[1]   = 1'b1;
    tick();
    check("rst_pre_m_req", bus.m_req, 1'b1);
    check("rst_pre_m_addr", bus.m_addr, 16'h0BAD);
    #2;
    reset_n   = 1'b0;
    bus.m_ack = 1'b1;
    #1;
    check("rst_mid_m_req", bus.m_req, 1'b0);
    check("rst_mid_m_addr", bus.m_addr, 0);
    check("rst_mid_m_wdata", bus.m_wdata, 0);
    check("rst_mid_m_w_en", bus.m_w_en, 1'b0);
    check("rst_mid_c_ack", bus.c_ack, 0);
    check("rst_mid_c_err", bus.c_err, 1'b0);
    check("rst_mid_c_rdata", bus.c_rdata, 0);
    tick();
    check("rst_mid_hold_c_ack", bus.c_ack, 0);
    check("rst_mid_hold_m_req", bus.m_req, 1'b0);
    bus.m_ack = 1'b0;
    bus.c_req = 4'b1001;
    reset_n   = 1'b1;
    await_grant(0, 1'b1, "rst_first_grant_ch0", ncyc);
    check("rst_first_spacing", ncyc, 2);
    await_grant(3, 1'b1, "rst_second_grant_ch3", ncyc);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of client channels, legal 2..8.
REQ-002 Parameter ADDR_W, default 16, address width.
REQ-003 Parameter DATA_W, default 256, data width.
REQ-004 Parameter TIMEOUT_CYC, default 64, max cycles to wait for m_ack, legal 2..65535.
REQ-005 clk  in  1  single clock, all logic on posedge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 c_req  in  NUM_CH  per-channel request, held until that channel's ack.
REQ-008 c_w_en  in  NUM_CH  per-channel write enable (1 write, 0 read).
REQ-009 c_addr  in  NUM_CH x ADDR_W  per-channel address.
REQ-010 c_wdata  in  NUM_CH x DATA_W  per-channel write data (replaces shared inout bus).
REQ-011 c_ack  out  NUM_CH  per-channel single-cycle acknowledge.
REQ-012 c_err  out  1  high with c_ack when the transaction timed out.
REQ-013 c_rdata  out  DATA_W  read data, valid in the c_ack cycle.
REQ-014 m_req, m_w_en  out  1 each  downstream request / write enable.
REQ-015 m_addr  out  ADDR_W; m_wdata  out  DATA_W  downstream address / write data.
REQ-016 m_ack  in  1; m_rdata  in  DATA_W  downstream acknowledge / read data.

Function
REQ-017 FSM states IDLE, ISSUE, ACK, RELEASE; encoding is one shared enum.
REQ-018 IDLE: when any c_req is high, pick one channel, register grant index, addr, w_en, wdata, go to ISSUE next cycle; otherwise stay.
REQ-019 Selection is round-robin: highest priority is (last_grant+1) mod NUM_CH, searching upward with wrap.
REQ-020 ISSUE: m_req=1, m_addr/m_w_en/m_wdata driven from registers, stable for the whole state.
REQ-021 ISSUE with m_ack=1 sampled: capture m_rdata (reads only; writes capture 0), go to ACK.
REQ-022 ISSUE timeout counter starts at 0 on entry and increments each cycle; reaching TIMEOUT_CYC-1 without m_ack -> ACK with error flag set and captured rdata 0.
REQ-023 ACK: m_req=0, c_ack[grant]=1 for exactly one cycle, c_err=error flag, c_rdata=captured data; last_grant<=grant; go to RELEASE.
REQ-024 RELEASE: one cycle, no arbitration, all acks low (lets client drop c_req); then IDLE.
REQ-025 Latency: c_req sampled at T in IDLE -> m_req at T+1; m_ack sampled at M -> c_ack at M+1; next grant sampled no earlier than M+3.
REQ-026 m_ack outside ISSUE (late or spurious) is ignored; it never produces c_ack.
REQ-027 Granted client dropping c_req before its ack does not abort; transaction completes and c_ack still pulses.
REQ-028 c_ack is one-hot or zero in every cycle; c_err is 0 whenever c_ack is zero.
REQ-029 c_req changes on non-granted channels during a transaction have no effect until the next IDLE.

Reset
REQ-030 reset_n low, at any time, forces immediately: state IDLE, m_req 0, m_w_en 0, m_addr 0, m_wdata 0, c_ack 0, c_err 0, c_rdata 0, timeout counter 0, last_grant NUM_CH-1 (channel 0 first).
REQ-031 Reset mid-transaction discards the transaction with no c_ack; first grant after release follows REQ-018.

Structure
REQ-032 Package mem_pkg holds default ADDR_W/DATA_W constants and arb_state_t enum.
REQ-033 Sub-module rr_pick: combinational round-robin selector (req vector, last_grant -> grant index, valid).

Verification
REQ-034 Single read ch2, m_ack 2 cycles after m_req, m_rdata=0xA5..A5 -> c_ack[2] one cycle, c_rdata=0xA5..A5, c_err 0.
REQ-035 All 4 channels request continuously after reset -> grant order 0,1,2,3,0 with no channel granted twice in a row.
REQ-036 m_ack never returned, TIMEOUT_CYC=8 -> m_req high exactly 8 cycles, then c_ack with c_err 1, c_rdata 0.
REQ-037 reset_n pulsed low during ISSUE -> m_req low immediately, no c_ack, after reset ch0 wins over ch3.
REQ-038 Write ch1 addr 0x1234 data 0xDEAD, m_ack then spurious m_ack in RELEASE -> m_addr/m_wdata stable in ISSUE, exactly one c_ack.
REQ-039 Bench assertions: c_ack one-hot pulse, m_req stable until m_ack, no m_ack-caused c_ack outside ISSUE.
